// File: rtl/memtrans_pkg.sv
// Shared types and constants for the byte-stream to memory transfer engine.
// Checksum flavour selected in memtrans_cksum via MEMTRANS_CRC8_EN.
package memtrans_pkg;

   localparam logic [3:0] OP_WRITE  = 4'h1;
   localparam logic [3:0] OP_READ   = 4'h2;
   localparam logic [7:0] ERR_RANGE = 8'hE1;
   localparam logic [7:0] ERR_TMO   = 8'hE2;
   localparam logic [7:0] CRC8_POLY = 8'h07;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR,
      S_CHK,
      S_WR_RX,
      S_WR_MEM,
      S_RD_MEM,
      S_RD_TX,
      S_FIN,
      S_TXW,
      S_TXB
   } state_e;

   function automatic logic [7:0] cksum_next(
      input logic [7:0] c,
      input logic [7:0] b,
      input logic       crc
   );
      logic [7:0] r;
      r = c ^ b;
      if (crc) begin
         for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ CRC8_POLY) : {r[6:0], 1'b0};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/memtrans_cksum.sv
// Running 8-bit checksum: XOR by default, CRC-8 (0x07) when
// MEMTRANS_CRC8_EN is defined. Clear has priority over update.
module memtrans_cksum
   import memtrans_pkg::*;
#(
   parameter logic [7:0] INIT = 8'h23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       upd_i,
   input  logic [7:0] byte_i,
   output logic [7:0] cksum_o
);

`ifdef MEMTRANS_CRC8_EN
   localparam logic USE_CRC = 1'b1;
`else
   localparam logic USE_CRC = 1'b0;
`endif

   logic [7:0] c_q, c_d;

   // next checksum value
   always_comb begin
      c_d = c_q;
      if (clr_i) begin
         c_d = INIT;
      end else if (upd_i) begin
         c_d = cksum_next(c_q, byte_i, USE_CRC);
      end
   end

   // checksum register, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         c_q <= INIT;
      end else begin
         c_q <= c_d;
      end
   end

   assign cksum_o = c_q;

endmodule

// File: rtl/memtrans_engine.sv
// Byte-stream command decoder moving words between a host byte link
// and NUM_CH memory channels. Option macro: MEMTRANS_CRC8_EN.
module memtrans_engine
   import memtrans_pkg::*;
#(
   parameter int          ADDR_BYTES = 3,
   parameter int          WORD_BYTES = 2,
   parameter int          NUM_CH     = 4,
   parameter int          TIMEOUT    = 1023,
   parameter logic [7:0]  CKSUM_INIT = 8'h23,
   localparam int         ADDR_W     = 8 * ADDR_BYTES,
   localparam int         DATA_W     = 8 * WORD_BYTES,
   localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [CH_W-1:0]   mem_ch,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err
);

   localparam int HDR_W = 2 * ADDR_W;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   state_e              ret_q, ret_d;
   logic                we_q, we_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [HDR_W-1:0]    hdr_q, hdr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic                last_q, last_d;
   logic                req_q, req_d;
   logic                mwe_q, mwe_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [7:0]          txd_q, txd_d;
   logic                err_q, err_d;

   logic                ck_clr, ck_upd;
   logic [7:0]          ck_byte, ck;
   logic                cmd_ok;
   logic [ADDR_W-1:0]   hdr_start, hdr_end, addr_nxt;
   logic                is_last;

   assign hdr_start = hdr_q[ADDR_W-1:0];
   assign hdr_end   = hdr_q[HDR_W-1:ADDR_W];
   assign addr_nxt  = addr_q + 1'b1;
   assign is_last   = (addr_nxt == hdr_end);
   assign cmd_ok    = rx_valid
                    && (rx_data[7:4] == OP_WRITE || rx_data[7:4] == OP_READ)
                    && ({1'b0, rx_data[3:0]} < 5'(NUM_CH));

   memtrans_cksum #(.INIT(CKSUM_INIT)) u_cksum (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (ck_clr),
      .upd_i   (ck_upd),
      .byte_i  (ck_byte),
      .cksum_o (ck)
   );

   // next-state and datapath decode
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      we_d    = we_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      addr_d  = addr_q;
      word_d  = word_q;
      last_d  = last_q;
      req_d   = req_q;
      mwe_d   = mwe_q;
      tmo_d   = tmo_q;
      txd_d   = txd_q;
      err_d   = err_q;
      ck_clr  = 1'b0;
      ck_upd  = 1'b0;
      ck_byte = rx_data;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_ok) begin
               we_d    = (rx_data[7:4] == OP_WRITE);
               ch_d    = CH_W'(rx_data[3:0]);
               err_d   = 1'b0;
               cnt_d   = '0;
               ck_clr  = 1'b1;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            if (rx_valid) begin
               hdr_d  = (hdr_q >> 8) | (HDR_W'(rx_data) << (HDR_W - 8));
               ck_upd = 1'b1;
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == 8'(2 * ADDR_BYTES - 1)) begin
                  state_d = S_CHK;
               end
            end
         end
         S_CHK: begin
            ck_clr  = 1'b1;
            cnt_d   = '0;
            state_d = S_TXW;
            if (hdr_end <= hdr_start) begin
               txd_d = ERR_RANGE;
               err_d = 1'b1;
               ret_d = S_IDLE;
            end else begin
               txd_d  = ck;
               addr_d = hdr_start;
               ret_d  = we_q ? S_WR_RX : S_RD_MEM;
            end
         end
         S_WR_RX: begin
            if (rx_valid) begin
               word_d = (word_q >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
               ck_upd = 1'b1;
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == 8'(WORD_BYTES - 1)) begin
                  state_d = S_WR_MEM;
               end
            end
         end
         S_WR_MEM, S_RD_MEM: begin
            if (!req_q) begin
               req_d = 1'b1;
               mwe_d = we_q;
               tmo_d = '0;
            end else if (mem_ack) begin
               req_d  = 1'b0;
               mwe_d  = 1'b0;
               addr_d = addr_nxt;
               last_d = is_last;
               cnt_d  = '0;
               if (we_q) begin
                  state_d = is_last ? S_FIN : S_WR_RX;
               end else begin
                  word_d  = mem_rdata;
                  state_d = S_RD_TX;
               end
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               mwe_d   = 1'b0;
               txd_d   = ERR_TMO;
               err_d   = 1'b1;
               ck_clr  = 1'b1;
               ret_d   = S_IDLE;
               state_d = S_TXW;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_RD_TX: begin
            txd_d   = word_q[7:0];
            word_d  = word_q >> 8;
            ck_byte = word_q[7:0];
            ck_upd  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            state_d = S_TXW;
            if (cnt_q == 8'(WORD_BYTES - 1)) begin
               ret_d = last_q ? S_FIN : S_RD_MEM;
            end else begin
               ret_d = S_RD_TX;
            end
         end
         S_FIN: begin
            txd_d   = ck;
            ck_clr  = 1'b1;
            ret_d   = S_IDLE;
            state_d = S_TXW;
         end
         S_TXW: begin
            if (tx_busy) begin
               state_d = S_TXB;
            end
         end
         S_TXB: begin
            if (!tx_busy) begin
               state_d = ret_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ret_q   <= S_IDLE;
         we_q    <= 1'b0;
         ch_q    <= '0;
         cnt_q   <= '0;
         hdr_q   <= '0;
         addr_q  <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         req_q   <= 1'b0;
         mwe_q   <= 1'b0;
         tmo_q   <= '0;
         txd_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         we_q    <= we_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         last_q  <= last_d;
         req_q   <= req_d;
         mwe_q   <= mwe_d;
         tmo_q   <= tmo_d;
         txd_q   <= txd_d;
         err_q   <= err_d;
      end
   end

   assign tx_start  = (state_q == S_TXW);
   assign tx_data   = txd_q;
   assign mem_req   = req_q;
   assign mem_we    = mwe_q;
   assign mem_ch    = ch_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = word_q;
   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;

endmodule

// File: tb/tb_memtrans_engine.sv
// Self-checking bench for memtrans_engine: command filter table,
// directed corner cases and randomized transfers against a list model.
module tb_memtrans_engine;

   localparam int         TMO  = 1023;
   localparam logic [7:0] SEED = 8'h23;

   typedef struct packed {
      logic        we;
      logic [1:0]  ch;
      logic [23:0] addr;
      logic [15:0] data;
   } txn_t;

   typedef struct {
      logic [7:0] cmd;
      logic       acc;
   } cvec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_ch;
   logic [23:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = 16'h0000;
   logic        busy;
   logic        err;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0]  act_tx[$];
   logic [7:0]  exp_tx[$];
   txn_t        act_mem[$];
   txn_t        exp_mem[$];
   logic [15:0] wq[$];
   logic [15:0] mem [logic [25:0]];

   int ack_delay = 1;
   int req_cnt = 0;
   int last_req_len = 0;
   bit req_seen = 0;
   int busy_left = 0;

   memtrans_engine #(.TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_ch    (mem_ch),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // UART transmitter stand-in: capture byte, stay busy a few cycles
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         tx_busy = 1'b0;
         busy_left = 0;
      end else if (tx_busy) begin
         busy_left--;
         if (busy_left <= 0) tx_busy = 1'b0;
      end else if (tx_start) begin
         act_tx.push_back(tx_data);
         tx_busy = 1'b1;
         busy_left = $urandom_range(1, 3);
      end
   end

   // memory stand-in: ack after ack_delay cycles of req (0 = never)
   initial forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
         logic [25:0] key;
         req_seen = 1;
         req_cnt++;
         key = {mem_ch, mem_addr};
         if (ack_delay > 0 && req_cnt == ack_delay) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               mem[key] = mem_wdata;
            end else begin
               if (!mem.exists(key)) mem[key] = 16'($urandom);
               mem_rdata = mem[key];
            end
            act_mem.push_back('{we: mem_we, ch: mem_ch,
                                addr: mem_addr, data: mem[key]});
         end
      end else begin
         if (req_cnt != 0) last_req_len = req_cnt;
         req_cnt = 0;
      end
   end

   function automatic logic [7:0] ck(input logic [7:0] c,
                                     input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
`ifdef MEMTRANS_CRC8_EN
      for (int i = 0; i < 8; i++)
         r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
`endif
      return r;
   endfunction

   function automatic logic [7:0] fold(input logic [7:0] q[$]);
      logic [7:0] c;
      c = SEED;
      foreach (q[i]) c = ck(c, q[i]);
      return c;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      tick();
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (busy && k < 5000) begin
         tick();
         k++;
      end
      chk(nm, busy, 0);
   endtask

   task automatic wait_tx(input int n, input string nm);
      int k;
      k = 0;
      while (!(act_tx.size() >= n && !tx_busy) && k < 2000) begin
         tick();
         k++;
      end
      chk(nm, act_tx.size() >= n, 1);
   endtask

   task automatic wait_mem(input int n, input string nm);
      int k;
      k = 0;
      while (act_mem.size() < n && k < 2000) begin
         tick();
         k++;
      end
      chk(nm, act_mem.size() >= n, 1);
   endtask

   // expected byte stream and memory traffic from the command rules
   task automatic model(input logic [3:0] op, input logic [3:0] ch,
                        input logic [23:0] s, input logic [23:0] e);
      logic [7:0]  hb[$];
      logic [7:0]  db[$];
      logic [15:0] d;
      logic [23:0] a;
      exp_tx.delete();
      exp_mem.delete();
      for (int i = 0; i < 3; i++) hb.push_back(s[8*i +: 8]);
      for (int i = 0; i < 3; i++) hb.push_back(e[8*i +: 8]);
      if (e <= s) begin
         exp_tx.push_back(8'hE1);
         return;
      end
      exp_tx.push_back(fold(hb));
      for (int w = 0; w < int'(e - s); w++) begin
         a = s + 24'(w);
         if (op == 4'h1) begin
            d = wq[w];
         end else begin
            if (!mem.exists({ch[1:0], a})) mem[{ch[1:0], a}] = 16'($urandom);
            d = mem[{ch[1:0], a}];
            exp_tx.push_back(d[7:0]);
            exp_tx.push_back(d[15:8]);
         end
         exp_mem.push_back('{we: (op == 4'h1), ch: ch[1:0], addr: a, data: d});
         db.push_back(d[7:0]);
         db.push_back(d[15:8]);
      end
      exp_tx.push_back(fold(db));
   endtask

   task automatic compare(input string tag, input logic exp_err);
      chk({tag, "_txlen"}, act_tx.size(), exp_tx.size());
      for (int i = 0; i < act_tx.size() && i < exp_tx.size(); i++)
         chk($sformatf("%s_tx%0d", tag, i), act_tx[i], exp_tx[i]);
      chk({tag, "_memlen"}, act_mem.size(), exp_mem.size());
      for (int i = 0; i < act_mem.size() && i < exp_mem.size(); i++)
         chk($sformatf("%s_mem%0d", tag, i), act_mem[i], exp_mem[i]);
      chk({tag, "_err"}, err, exp_err);
   endtask

   task automatic do_cmd(input string tag, input logic [3:0] op,
                         input logic [3:0] ch, input logic [23:0] s,
                         input logic [23:0] e, input int dly);
      int nw;
      nw = (e > s) ? int'(e - s) : 0;
      if (op == 4'h1)
         while (wq.size() < nw) wq.push_back(16'($urandom));
      model(op, ch, s, e);
      if (dly == 0 && nw > 0) begin
         exp_tx = exp_tx[0:0];
         exp_tx.push_back(8'hE2);
         exp_mem.delete();
      end
      act_tx.delete();
      act_mem.delete();
      ack_delay = dly;
      req_seen = 0;
      send_byte({op, ch});
      for (int i = 0; i < 3; i++) send_byte(s[8*i +: 8]);
      for (int i = 0; i < 3; i++) send_byte(e[8*i +: 8]);
      if (op == 4'h1 && nw > 0 && dly > 0) begin
         wait_tx(1, {tag, "_ackwait"});
         for (int w = 0; w < nw; w++) begin
            send_byte(wq[w][7:0]);
            send_byte(wq[w][15:8]);
            wait_mem(w + 1, {tag, "_memwait"});
         end
      end
      wait_idle({tag, "_idle"});
      compare(tag, (nw == 0) || (dly == 0));
      wq.delete();
   endtask

   initial begin
      cvec_t       tab[8];
      logic [3:0]  op, ch;
      logic [23:0] s, e;
      int          len;

      tab[0] = '{8'h30, 1'b0};
      tab[1] = '{8'h1F, 1'b0};
      tab[2] = '{8'h00, 1'b0};
      tab[3] = '{8'h14, 1'b0};
      tab[4] = '{8'hF1, 1'b0};
      tab[5] = '{8'h13, 1'b1};
      tab[6] = '{8'h20, 1'b1};
      tab[7] = '{8'h12, 1'b1};

      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_txs", tx_start, 0);
      chk("rst_txd", tx_data, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_bus", {mem_ch, mem_addr, mem_wdata}, 0);
      rst = 1'b1;
      tick();

      // command filter table; accepted ones end with a range error
      for (int t = 0; t < 8; t++) begin
         act_tx.delete();
         send_byte(tab[t].cmd);
         chk($sformatf("tab%0d_busy", t), busy, tab[t].acc);
         if (tab[t].acc) begin
            chk($sformatf("tab%0d_errclr", t), err, 0);
            repeat (6) send_byte(8'h00);
            wait_idle($sformatf("tab%0d_idle", t));
            chk($sformatf("tab%0d_txn", t), act_tx.size(), 1);
            if (act_tx.size() == 1)
               chk($sformatf("tab%0d_e1", t), act_tx[0], 8'hE1);
            chk($sformatf("tab%0d_err", t), err, 1);
         end else begin
            repeat (10) tick();
            chk($sformatf("tab%0d_notx", t), act_tx.size(), 0);
         end
      end

      // WRITE ch1 0x10..0x12 with data 34 12 78 56
      wq.delete();
      wq.push_back(16'h1234);
      wq.push_back(16'h5678);
      do_cmd("wr", 4'h1, 4'h1, 24'h10, 24'h12, 2);
`ifndef MEMTRANS_CRC8_EN
      if (act_tx.size() == 2) begin
         chk("wr_hdr_const", act_tx[0], 8'h21);
         chk("wr_fin_const", act_tx[1], 8'h2B);
      end
`endif

      // READ ch0 0x0..0x1, data BEEF after 3 cycles
      mem[{2'd0, 24'h0}] = 16'hBEEF;
      do_cmd("rd", 4'h2, 4'h0, 24'h0, 24'h1, 3);
`ifndef MEMTRANS_CRC8_EN
      if (act_tx.size() == 4) begin
         chk("rd_hdr_const", act_tx[0], 8'h22);
         chk("rd_b0_const", act_tx[1], 8'hEF);
         chk("rd_b1_const", act_tx[2], 8'hBE);
         chk("rd_fin_const", act_tx[3], 8'h72);
      end
`endif

      // empty range
      do_cmd("rng", 4'h1, 4'h2, 24'h5, 24'h5, 1);
      chk("rng_noreq", req_seen, 0);

      // memory never answers
      do_cmd("tmo", 4'h2, 4'h3, 24'h100, 24'h101, 0);
      chk("tmo_len", last_req_len, TMO);

      // reset while a write is waiting on memory
      act_tx.delete();
      act_mem.delete();
      ack_delay = 0;
      send_byte(8'h11);
      send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h42); send_byte(8'h00); send_byte(8'h00);
      wait_tx(1, "mrst_ack");
      send_byte(8'hAA);
      send_byte(8'h55);
      len = 0;
      while (!mem_req && len < 100) begin
         tick();
         len++;
      end
      chk("mrst_reqhi", mem_req, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mrst_req", mem_req, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_txs", tx_start, 0);
      chk("mrst_bus", {mem_ch, mem_addr, mem_wdata}, 0);
      tick();
      rst = 1'b1;
      repeat (3) tick();

      // randomized transfers
      for (int n = 0; n < 30; n++) begin
         op  = 4'($urandom_range(1, 2));
         ch  = 4'($urandom_range(0, 3));
         len = $urandom_range(1, 4);
         s   = 24'($urandom);
         if (s < 24'd8) s = 24'd8;
         if ($urandom_range(0, 4) == 0) s = 24'hFFFFFF - 24'(len);
         e   = s + 24'(len);
         if ($urandom_range(0, 6) == 0) e = s - 24'($urandom_range(0, 3));
         do_cmd($sformatf("rnd%0d", n), op, ch, s, e,
                $urandom_range(1, 4));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
